pc_predict_select: RTL and testbench

//  Fetch-stage PC generator for the pipelined Y86-64 core. Holds the fetch PC, predicts the

---
 rtl/y86_pkg.sv | 17 +
 rtl/ret_addr_stack.sv | 51 +++++
 rtl/pc_predict_select.sv | 123 ++++++++++++
 tb/tb_pc_predict_select.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes and fetch-PC states.
// Imported by pc_predict_select and ret_addr_stack.
package y86_pkg;

  localparam logic [3:0] IHALT = 4'h0;
  localparam logic [3:0] INOP  = 4'h1;
  localparam logic [3:0] IJXX  = 4'h7;
  localparam logic [3:0] ICALL = 4'h8;
  localparam logic [3:0] IRET  = 4'h9;

  typedef enum logic [1:0] {
    RUN,
    RET_WAIT,
    HALTED
  } pc_state_t;

endpackage

// File: rtl/ret_addr_stack.sv
// Circular return-address stack: a push when full overwrites the oldest
// entry and the count saturates; a pop when empty is ignored.
import y86_pkg::*;

module ret_addr_stack #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  input  logic [63:0]              data_i,
  output logic [63:0]              top_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] top_idx;
  logic [AW:0]   count_q;

  assign top_idx = ptr_q - AW'(1);
  assign top_o   = mem_q[top_idx];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (push_i && !clear_i && !rst) begin
      mem_q[ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else if (push_i) begin
      ptr_q <= ptr_q + AW'(1);
      if (count_q != FULL) begin
        count_q <= count_q + (AW+1)'(1);
      end
    end else if (pop_i && count_q != '0) begin
      ptr_q   <= top_idx;
      count_q <= count_q - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/pc_predict_select.sv
// Fetch-stage PC register, next-PC predictor and misprediction repair.
// Define RAS_RETURN_PREDICT_EN to predict ret targets with a return stack.
import y86_pkg::*;

module pc_predict_select #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_valid,
  input  logic        f_stall,
  input  logic [3:0]  f_icode,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic [3:0]  M_icode,
  input  logic        M_cnd,
  input  logic [63:0] M_valA,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valM,
  input  logic [63:0] W_pred_pc,
  output logic [63:0] f_pc,
  output logic [63:0] pred_pc,
  output logic        redirect,
  output logic        ret_stall
);

  logic [63:0] f_pc_q, f_pc_d;
  pc_state_t   state_q, state_d;
  logic        ret_stall_q, ret_stall_d;
  logic        m_mispredict;
  logic        w_fix;
  logic        fetch_ok;
  logic [63:0] ret_pred;

  assign m_mispredict = (M_icode == IJXX) && !M_cnd;
  assign fetch_ok     = f_valid && !f_stall && (state_q == RUN);
  assign redirect     = !rst && (m_mispredict || w_fix);

`ifdef RAS_RETURN_PREDICT_EN
  localparam bit HAS_RAS = 1'b1;

  logic                       ras_push;
  logic                       ras_pop;
  logic [63:0]                ras_top;
  logic [$clog2(RAS_DEPTH):0] ras_count;

  assign w_fix    = (W_icode == IRET) && (W_valM != W_pred_pc);
  assign ras_push = fetch_ok && !redirect && (f_icode == ICALL);
  assign ras_pop  = fetch_ok && !redirect && (f_icode == IRET);
  assign ret_pred = (ras_count != '0) ? ras_top : f_valP;

  ret_addr_stack #(
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk    (clk),
    .rst    (rst),
    .push_i (ras_push),
    .pop_i  (ras_pop),
    .clear_i(w_fix),
    .data_i (f_valP),
    .top_o  (ras_top),
    .count_o(ras_count)
  );
`else
  localparam bit HAS_RAS = 1'b0;

  logic unused_cfg;

  assign unused_cfg = ^W_pred_pc ^ RAS_DEPTH[0];
  assign w_fix      = (W_icode == IRET) && (state_q == RET_WAIT);
  assign ret_pred   = f_valP;
`endif

  always_comb begin
    pred_pc = f_valP;
    unique case (1'b1)
      f_icode == IJXX,
      f_icode == ICALL: pred_pc = f_valC;
      f_icode == IRET:  pred_pc = ret_pred;
      default:          pred_pc = f_valP;
    endcase
  end

  // A squash from M outranks the older W ret: its path is the live one.
  always_comb begin
    f_pc_d  = f_pc_q;
    state_d = state_q;
    if (m_mispredict) begin
      f_pc_d  = M_valA;
      state_d = RUN;
    end else if (w_fix) begin
      f_pc_d  = W_valM;
      state_d = RUN;
    end else if (fetch_ok) begin
      unique case (1'b1)
        f_icode == IHALT: state_d = HALTED;
        f_icode == IRET && !HAS_RAS: begin
          f_pc_d  = pred_pc;
          state_d = RET_WAIT;
        end
        default: f_pc_d = pred_pc;
      endcase
    end
    ret_stall_d = (state_d == RET_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_pc_q      <= RESET_PC;
      state_q     <= RUN;
      ret_stall_q <= 1'b0;
    end else begin
      f_pc_q      <= f_pc_d;
      state_q     <= state_d;
      ret_stall_q <= ret_stall_d;
    end
  end

  assign f_pc      = f_pc_q;
  assign ret_stall = ret_stall_q;

endmodule

// File: tb/tb_pc_predict_select.sv
// Bench for pc_predict_select: vector table, directed ret sequences,
// then random stimulus against a queue-based reference model.
module tb_pc_predict_select;

  localparam logic [63:0] RST_PC = 64'h10;
  localparam int          DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_valid, f_stall;
  logic [3:0]  f_icode;
  logic [63:0] f_valC, f_valP;
  logic [3:0]  M_icode;
  logic        M_cnd;
  logic [63:0] M_valA;
  logic [3:0]  W_icode;
  logic [63:0] W_valM, W_pred_pc;
  logic [63:0] f_pc, pred_pc;
  logic        redirect, ret_stall;

  int checks   = 0;
  int failures = 0;

  pc_predict_select #(
    .RESET_PC (RST_PC),
    .RAS_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .f_valid  (f_valid),
    .f_stall  (f_stall),
    .f_icode  (f_icode),
    .f_valC   (f_valC),
    .f_valP   (f_valP),
    .M_icode  (M_icode),
    .M_cnd    (M_cnd),
    .M_valA   (M_valA),
    .W_icode  (W_icode),
    .W_valM   (W_valM),
    .W_pred_pc(W_pred_pc),
    .f_pc     (f_pc),
    .pred_pc  (pred_pc),
    .redirect (redirect),
    .ret_stall(ret_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic s,
                       input logic [3:0] fi, input logic [63:0] vc,
                       input logic [63:0] vp, input logic [3:0] mi,
                       input logic mc, input logic [63:0] ma,
                       input logic [3:0] wi, input logic [63:0] wm,
                       input logic [63:0] wp);
    rst = r; f_valid = v; f_stall = s; f_icode = fi;
    f_valC = vc; f_valP = vp;
    M_icode = mi; M_cnd = mc; M_valA = ma;
    W_icode = wi; W_valM = wm; W_pred_pc = wp;
  endtask

  typedef struct {
    logic        r, v, s;
    logic [3:0]  fi;
    logic [63:0] vc, vp;
    logic [3:0]  mi;
    logic        mc;
    logic [63:0] ma;
    logic [3:0]  wi;
    logic [63:0] wm, wp;
    logic [63:0] e_pc, e_pred;
    logic        e_red, e_rs;
  } vec_t;

  function automatic vec_t mk(
      logic r, logic v, logic s, logic [3:0] fi,
      logic [63:0] vc, logic [63:0] vp,
      logic [3:0] mi, logic mc, logic [63:0] ma,
      logic [3:0] wi, logic [63:0] wm, logic [63:0] wp,
      logic [63:0] e_pc, logic [63:0] e_pred,
      logic e_red, logic e_rs);
    vec_t t;
    t.r = r; t.v = v; t.s = s; t.fi = fi; t.vc = vc; t.vp = vp;
    t.mi = mi; t.mc = mc; t.ma = ma; t.wi = wi; t.wm = wm; t.wp = wp;
    t.e_pc = e_pc; t.e_pred = e_pred; t.e_red = e_red; t.e_rs = e_rs;
    return t;
  endfunction

  // Reference model: mode 0 run, 1 waiting on ret, 2 halted
  logic [63:0] m_pc;
  int          m_mode;
  logic        m_rs;
  logic [63:0] m_ras[$];

  task automatic model_eval(output logic [63:0] pred, output logic red,
                            output logic mis, output logic wfix);
    pred = f_valP;
    if (f_icode == 4'h7 || f_icode == 4'h8) pred = f_valC;
`ifdef RAS_RETURN_PREDICT_EN
    else if (f_icode == 4'h9 && m_ras.size() > 0) pred = m_ras[$];
    wfix = (W_icode == 4'h9) && (W_valM != W_pred_pc);
`else
    wfix = (W_icode == 4'h9) && (m_mode == 1);
`endif
    mis = (M_icode == 4'h7) && !M_cnd;
    red = !rst && (mis || wfix);
  endtask

  task automatic model_commit();
    logic [63:0] pred;
    logic red, mis, wfix, fetch;
    model_eval(pred, red, mis, wfix);
    fetch = f_valid && !f_stall && m_mode == 0;
    if (rst) begin
      m_pc = RST_PC; m_mode = 0; m_rs = 1'b0;
      m_ras.delete();
      return;
    end
`ifdef RAS_RETURN_PREDICT_EN
    if (wfix) m_ras.delete();
    else if (fetch && !red) begin
      if (f_icode == 4'h8) begin
        if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
        m_ras.push_back(f_valP);
      end else if (f_icode == 4'h9 && m_ras.size() > 0) begin
        void'(m_ras.pop_back());
      end
    end
`endif
    if (mis) begin
      m_pc = M_valA; m_mode = 0;
    end else if (wfix) begin
      m_pc = W_valM; m_mode = 0;
    end else if (fetch) begin
      if (f_icode == 4'h0) m_mode = 2;
`ifndef RAS_RETURN_PREDICT_EN
      else if (f_icode == 4'h9) begin
        m_pc = f_valP; m_mode = 1;
      end
`endif
      else m_pc = pred;
    end
    m_rs = (m_mode == 1);
  endtask

  vec_t tbl[15];

  initial begin
    logic [63:0] e_pred;
    logic e_red, e_mis, e_wfix;
    int r;

    tbl[0]  = mk(1,1,0,1, 0,'h11, 7,0,'h99, 9,'h77,0,
                 'h10,'h11,0,0);
    tbl[1]  = mk(0,1,0,7, 'h80,'h19, 1,0,0, 1,0,0,
                 'h10,'h80,0,0);
    tbl[2]  = mk(0,1,0,1, 0,'h81, 1,0,0, 1,0,0,
                 'h80,'h81,0,0);
    tbl[3]  = mk(0,1,0,1, 0,'h82, 7,0,'h19, 1,0,0,
                 'h81,'h82,1,0);
    tbl[4]  = mk(0,1,0,1, 0,'h1A, 1,0,0, 1,0,0,
                 'h19,'h1A,0,0);
    tbl[5]  = mk(0,1,0,1, 0,'h1B, 7,1,'h33, 1,0,0,
                 'h1A,'h1B,0,0);
    tbl[6]  = mk(0,0,0,1, 0,'h55, 1,0,0, 1,0,0,
                 'h1B,'h55,0,0);
    tbl[7]  = mk(0,1,1,8, 'h200,'h1F, 1,0,0, 1,0,0,
                 'h1B,'h200,0,0);
    tbl[8]  = mk(0,1,0,0, 0,'h1C, 1,0,0, 1,0,0,
                 'h1B,'h1C,0,0);
    tbl[9]  = mk(0,1,0,1, 0,'h44, 1,0,0, 1,0,0,
                 'h1B,'h44,0,0);
    tbl[10] = mk(0,1,0,1, 0,'h44, 1,0,0, 1,0,0,
                 'h1B,'h44,0,0);
    tbl[11] = mk(0,1,1,1, 0,'h45, 7,0,'h30, 1,0,0,
                 'h1B,'h45,1,0);
    tbl[12] = mk(0,1,0,1, 0,'h31, 1,0,0, 1,0,0,
                 'h30,'h31,0,0);
    tbl[13] = mk(0,1,0,1, 0,'h32, 7,0,'h60, 9,'h70,0,
                 'h31,'h32,1,0);
    tbl[14] = mk(0,1,0,1, 0,'h61, 1,0,0, 1,0,0,
                 'h60,'h61,0,0);

    drive(1,0,0,1, 0,0, 1,0,0, 1,0,0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].fi, tbl[i].vc,
            tbl[i].vp, tbl[i].mi, tbl[i].mc, tbl[i].ma,
            tbl[i].wi, tbl[i].wm, tbl[i].wp);
      #1;
      chk($sformatf("vec%0d f_pc", i), f_pc, tbl[i].e_pc);
      chk($sformatf("vec%0d pred_pc", i), pred_pc, tbl[i].e_pred);
      chk($sformatf("vec%0d redirect", i), 64'(redirect),
          64'(tbl[i].e_red));
      chk($sformatf("vec%0d ret_stall", i), 64'(ret_stall),
          64'(tbl[i].e_rs));
    end

`ifdef RAS_RETURN_PREDICT_EN
    @(negedge clk);
    drive(0,1,0,8, 'h100,'h2A, 1,0,0, 1,0,0);
    #1 chk("ras call pred", pred_pc, 'h100);
    @(negedge clk);
    drive(0,1,0,9, 0,'h101, 1,0,0, 1,0,0);
    #1 chk("ras ret f_pc", f_pc, 'h100);
    chk("ras ret pred", pred_pc, 'h2A);
    @(negedge clk);
    drive(0,1,0,1, 0,'h2B, 1,0,0, 9,'h2A,'h2A);
    #1 chk("ras hit f_pc", f_pc, 'h2A);
    chk("ras hit redirect", 64'(redirect), 0);
    @(negedge clk);
    drive(0,1,0,8, 'h300,'h2C, 1,0,0, 1,0,0);
    #1 chk("ras call2 f_pc", f_pc, 'h2B);
    @(negedge clk);
    drive(0,1,0,1, 0,'h301, 1,0,0, 9,'h40,'h2A);
    #1 chk("ras miss f_pc", f_pc, 'h300);
    chk("ras miss redirect", 64'(redirect), 1);
    @(negedge clk);
    drive(0,1,0,9, 0,'h41, 1,0,0, 1,0,0);
    #1 chk("ras clr f_pc", f_pc, 'h40);
    chk("ras clr pred", pred_pc, 'h41);
    chk("ras clr redirect", 64'(redirect), 0);
`else
    @(negedge clk);
    drive(0,1,0,9, 0,'h62, 1,0,0, 1,0,0);
    #1 chk("ret pred", pred_pc, 'h62);
    chk("ret stall0", 64'(ret_stall), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(0,1,0,1, 0,64'h90 + 64'(k), 1,0,0, 1,0,0);
      #1 chk($sformatf("ret hold%0d f_pc", k), f_pc, 'h62);
      chk($sformatf("ret hold%0d stall", k), 64'(ret_stall), 1);
      chk($sformatf("ret hold%0d redir", k), 64'(redirect), 0);
    end
    @(negedge clk);
    drive(0,1,0,1, 0,'h93, 1,0,0, 9,'h55,0);
    #1 chk("ret W redirect", 64'(redirect), 1);
    @(negedge clk);
    drive(0,1,0,1, 0,'h56, 1,0,0, 1,0,0);
    #1 chk("ret W f_pc", f_pc, 'h55);
    chk("ret W stall", 64'(ret_stall), 0);
`endif

    @(negedge clk);
    drive(1,0,0,1, 0,0, 1,0,0, 1,0,0);
    #1 model_commit();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst     = ($urandom_range(0, 63) == 0);
      f_valid = ($urandom_range(0, 7) != 0);
      f_stall = ($urandom_range(0, 5) == 0);
      r = int'($urandom_range(0, 15));
      if (r < 5)       f_icode = 4'h1;
      else if (r < 8)  f_icode = 4'h7;
      else if (r < 10) f_icode = 4'h8;
      else if (r < 13) f_icode = 4'h9;
      else if (r == 13) f_icode = 4'h0;
      else             f_icode = 4'($urandom);
      f_valC  = {$urandom, $urandom};
      f_valP  = {$urandom, $urandom};
      M_icode = ($urandom_range(0, 3) == 0) ? 4'h7 : 4'($urandom);
      M_cnd   = 1'($urandom);
      M_valA  = {$urandom, $urandom};
      W_icode = ($urandom_range(0, 3) == 0) ? 4'h9 : 4'($urandom);
      W_valM  = {$urandom, $urandom};
      W_pred_pc = $urandom_range(0, 1) ? W_valM : {$urandom, $urandom};
      #1;
      model_eval(e_pred, e_red, e_mis, e_wfix);
      chk("rnd f_pc", f_pc, m_pc);
      chk("rnd pred_pc", pred_pc, e_pred);
      chk("rnd redirect", 64'(redirect), 64'(e_red));
      chk("rnd ret_stall", 64'(ret_stall), 64'(m_rs));
      model_commit();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
